// File: rtl/player_input_tx.sv
// Serial transmitter for the player button byte {2'b10, buttons[5:0]} as a UART-style frame.
// Optional even-parity bit is enabled by defining PLAYER_TX_PARITY_EN.
module player_input_tx #(
  parameter int unsigned BAUD_DIV = 868
) (
  input  logic       clock_in,
  input  logic       reset_in,
  input  logic [5:0] buttons_in,
  input  logic       send_in,
  output logic       tx_out,
  output logic       busy_out,
  output logic       done_out
);

`ifdef PLAYER_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic [15:0] BIT_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] DONE_PRE = 16'(BAUD_DIV - 2);

  state_t      state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic [5:0]  last_sent;
  logic        bit_end;
`ifdef PLAYER_TX_PARITY_EN
  logic        parity_bit;
`endif

  assign bit_end = (baud_cnt == BIT_LAST);

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      last_sent <= '0;
      tx_out    <= 1'b1;
      busy_out  <= 1'b0;
      done_out  <= 1'b0;
`ifdef PLAYER_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      done_out <= 1'b0;
      if (state != IDLE)
        baud_cnt <= bit_end ? '0 : baud_cnt + 16'd1;
      case (state)
        IDLE: begin
          if (send_in || (buttons_in != last_sent)) begin
            shift_reg <= {2'b10, buttons_in};
            last_sent <= buttons_in;
`ifdef PLAYER_TX_PARITY_EN
            parity_bit <= ^{2'b10, buttons_in};
`endif
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            tx_out    <= 1'b0;
            busy_out  <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx_out <= shift_reg[0];
            state  <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == 3'd7) begin
`ifdef PLAYER_TX_PARITY_EN
              tx_out <= parity_bit;
              state  <= PARITY;
`else
              tx_out <= 1'b1;
              state  <= STOP;
`endif
            end else begin
              // Next bit is presented from bit 1 before the shift lands.
              tx_out    <= shift_reg[1];
              shift_reg <= {1'b0, shift_reg[7:1]};
              bit_cnt   <= bit_cnt + 3'd1;
            end
          end
        end
`ifdef PLAYER_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            tx_out <= 1'b1;
            state  <= STOP;
          end
        end
`endif
        STOP: begin
          // Registered pulse: raise one cycle early so it lands on the last stop cycle.
          if (baud_cnt == DONE_PRE)
            done_out <= 1'b1;
          if (bit_end) begin
            busy_out <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_player_input_tx.sv
// Scoreboard bench for player_input_tx with BAUD_DIV=4; frame width follows PLAYER_TX_PARITY_EN.
module tb_player_input_tx;
  localparam int BD = 4;
`ifdef PLAYER_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset_in = 1'b1;
  logic [5:0] buttons_in = '0;
  logic       send_in = 1'b0;
  logic       tx_out, busy_out, done_out;

  player_input_tx #(.BAUD_DIV(BD)) dut (
    .clock_in  (clk),
    .reset_in  (reset_in),
    .buttons_in(buttons_in),
    .send_in   (send_in),
    .tx_out    (tx_out),
    .busy_out  (busy_out),
    .done_out  (done_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         gap;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor state
  logic samp [64];
  int cyc = 0, done_at = 0, done_cnt = 0, gap = 1000, gap_seen = 0;

  task automatic check_frame();
    logic [7:0] d;
    int stable;
    exp_t e;
    d = '0;
    stable = 1;
    check("frame_len", cyc, NB * BD);
    check("done_pos", done_at, NB * BD);
    check("done_count", done_cnt, 1);
    check("idle_tx_high", int'(tx_out), 1);
    if (cyc == NB * BD) begin
      for (int b = 0; b < NB; b++)
        for (int j = 1; j < BD; j++)
          if (samp[b * BD + j] !== samp[b * BD]) stable = 0;
      check("bit_hold", stable, 1);
      check("start_bit", int'(samp[0]), 0);
      check("stop_bit", int'(samp[(NB - 1) * BD]), 1);
      for (int i = 0; i < 8; i++) d[i] = samp[(i + 1) * BD];
    end
    if (sb.size() == 0) begin
      check("unexpected_frame", int'(d), -1);
    end else begin
      e = sb.pop_front();
      check("data", int'(d), int'(e.data));
      if (e.gap >= 0) check("gap", gap_seen, e.gap);
`ifdef PLAYER_TX_PARITY_EN
      if (cyc == NB * BD) check("parity", int'(samp[9 * BD]), int'(^e.data));
`endif
    end
  endtask

  always @(negedge clk) begin
    if (reset_in) begin
      cyc = 0; done_cnt = 0; done_at = 0; gap = 1000;
    end else if (busy_out) begin
      if (cyc == 0) begin gap_seen = gap; gap = 0; end
      if (cyc < 64) samp[cyc] = tx_out;
      cyc++;
      if (done_out) begin done_cnt++; done_at = cyc; end
    end else begin
      if (done_out) check("done_while_idle", 1, 0);
      if (cyc > 0) check_frame();
      cyc = 0; done_cnt = 0; done_at = 0;
      gap++;
    end
  end

  task automatic wait_busy();
    int n = 0;
    while (!busy_out && n < 200) begin @(negedge clk); n++; end
    if (!busy_out) check("busy_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!done_out && n < 200) begin @(negedge clk); n++; end
    if (!done_out) check("done_timeout", 0, 1);
  endtask

  task automatic pulse_send();
    send_in = 1'b1;
    @(negedge clk);
    send_in = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", int'(tx_out), 1);
    check("rst_busy", int'(busy_out), 0);
    check("rst_done", int'(done_out), 0);
    reset_in = 1'b0;

    // No change, no send: stays idle
    repeat (10) @(negedge clk);
    check("idle_no_frame", int'(busy_out), 0);

    // Button change triggers frame 8'h81
    sb.push_back('{8'h81, -1});
    buttons_in = 6'b000001;
    wait_busy();
    wait_done();
    repeat (5) @(negedge clk);

    // send_in in IDLE resends; send_in mid-frame is ignored
    sb.push_back('{8'h81, -1});
    pulse_send();
    wait_busy();
    repeat (19) @(negedge clk);
    pulse_send();
    wait_done();
    repeat (10) @(negedge clk);
    check("no_queued_send", int'(busy_out), 0);

    // Persistent change at cycle 10 -> one idle cycle then 8'hA0
    sb.push_back('{8'h81, -1});
    pulse_send();
    wait_busy();
    repeat (9) @(negedge clk);
    buttons_in = 6'b100000;
    sb.push_back('{8'hA0, 1});
    wait_done();
    wait_done();
    repeat (10) @(negedge clk);

    // Change that reverts before IDLE -> no extra frame
    sb.push_back('{8'hA0, -1});
    pulse_send();
    wait_busy();
    repeat (9) @(negedge clk);
    buttons_in = 6'b000001;
    repeat (10) @(negedge clk);
    buttons_in = 6'b100000;
    wait_done();
    repeat (10) @(negedge clk);
    check("no_revert_frame", int'(busy_out), 0);

    // send_in together with a change -> exactly one frame 8'h83
    sb.push_back('{8'h83, -1});
    buttons_in = 6'b000011;
    pulse_send();
    wait_done();
    repeat (10) @(negedge clk);
    check("single_frame", int'(busy_out), 0);

    // Reset at cycle 17 aborts; after release last_sent=0 retriggers
    buttons_in = 6'b000001;
    wait_busy();
    repeat (16) @(negedge clk);
    reset_in = 1'b1;
    @(negedge clk);
    check("abort_tx", int'(tx_out), 1);
    check("abort_busy", int'(busy_out), 0);
    check("abort_done", int'(done_out), 0);
    @(negedge clk);
    sb.push_back('{8'h81, -1});
    reset_in = 1'b0;
    wait_busy();
    wait_done();
    repeat (10) @(negedge clk);

    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
